// File: rtl/axi_arb_pkg.sv
// Shared types and the round-robin pick used by the AXI read arbiter.
package axi_arb_pkg;

  // Index type is sized for the largest supported requester count (8), so
  // one package serves every legal N_REQ.
  localparam int MAX_REQ = 8;
  typedef logic [2:0] idx_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Round-robin: first set bit of req at or after last+1, wrapping modulo n.
  // Candidates are scanned farthest-first so the nearest hit is written last.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input idx_t last, input int n);
    pick_t p;
    int    c;
    p = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        c = (int'(last) + i) % n;
        if (req[c[2:0]]) begin
          p.found = 1'b1;
          p.idx   = c[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Routing FIFO: remembers which requester issued each outstanding read.
module sync_fifo
  import axi_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  idx_t          push_data,
  input  logic          pop,
  output idx_t          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  idx_t        mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = CW'(wr_ptr_q - rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on guarded push/pop; both may happen in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer state, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_rd_arb.sv
// Round-robin arbiter sharing one single-beat, in-order AXI read channel.
module axi_rd_arb
  import axi_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 i_req_addr_vld,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] i_req_addr,
  output logic [N_REQ-1:0]                 o_req_addr_rdy,
  output logic [N_REQ-1:0]                 o_req_data_vld,
  output logic [DATA_WIDTH-1:0]            o_req_data,
  input  logic [N_REQ-1:0]                 i_req_data_rdy,
  output logic                             o_ar_vld,
  output logic [ADDR_WIDTH-1:0]            o_ar_addr,
  input  logic                             i_ar_rdy,
  input  logic                             i_r_vld,
  input  logic [DATA_WIDTH-1:0]            i_r_data,
  output logic                             o_r_rdy,
  output logic [$clog2(DEPTH+1)-1:0]       o_outstanding,
  output logic                             o_busy
);
  localparam int CW = $clog2(DEPTH+1);

  logic                  ar_vld_q, ar_vld_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  idx_t                  last_grant_q, last_grant_d;

  logic [MAX_REQ-1:0]    vld_pad, drdy_pad;
  logic [ADDR_WIDTH-1:0] win_addr;
  pick_t                 pick;
  logic                  ar_free, can_accept, accept, r_fire;
  logic                  fifo_full, fifo_empty;
  idx_t                  head;
  logic [CW-1:0]         count;

  sync_fifo #(.DEPTH(DEPTH), .CW(CW)) u_route (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_data(pick.idx),
    .pop      (r_fire),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  // Widen per-requester vectors to the package width for indexing by idx_t.
  always_comb begin
    vld_pad  = '0;
    drdy_pad = '0;
    for (int j = 0; j < N_REQ; j++) begin
      vld_pad[j]  = i_req_addr_vld[j];
      drdy_pad[j] = i_req_data_rdy[j];
    end
  end

  assign pick       = rr_pick(vld_pad, last_grant_q, N_REQ);
  assign ar_free    = !ar_vld_q || i_ar_rdy;
  // A pop this cycle deliberately does not open a slot (count, not pop).
  assign can_accept = ar_free && !fifo_full;
  assign accept     = pick.found && can_accept;

  assign o_r_rdy    = !fifo_empty && drdy_pad[head];
  assign r_fire     = i_r_vld && o_r_rdy;
  assign o_req_data = i_r_data;

  // Per-requester handshakes: address rdy to the winner, data vld to the head.
  always_comb begin
    o_req_addr_rdy = '0;
    o_req_data_vld = '0;
    win_addr       = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick.found && pick.idx == idx_t'(j)) begin
        o_req_addr_rdy[j] = can_accept;
        win_addr          = i_req_addr[j];
      end
      if (i_r_vld && !fifo_empty && head == idx_t'(j)) o_req_data_vld[j] = 1'b1;
    end
  end

  // AR register: load on accept, clear on drain, otherwise hold (AXI stable).
  always_comb begin
    ar_vld_d     = ar_vld_q;
    ar_addr_d    = ar_addr_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      ar_vld_d     = 1'b1;
      ar_addr_d    = win_addr;
      last_grant_d = pick.idx;
    end else if (ar_vld_q && i_ar_rdy) begin
      ar_vld_d = 1'b0;
    end
  end

  // Reset parks last_grant at N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_vld_q     <= 1'b0;
      ar_addr_q    <= '0;
      last_grant_q <= idx_t'(N_REQ-1);
    end else begin
      ar_vld_q     <= ar_vld_d;
      ar_addr_q    <= ar_addr_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_ar_vld      = ar_vld_q;
  assign o_ar_addr     = ar_addr_q;
  assign o_outstanding = count;
  assign o_busy        = ar_vld_q || (count != '0);

endmodule
